// File: rtl/slow_mem_pkg.sv
// slow_mem_pkg: shared types and widths for the cache-side slow memory responder.
package slow_mem_pkg;
    localparam int BLK_W = 128;
    localparam int ADDR_W = 28;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/slow_mem_array.sv
// slow_mem_array: single-port synchronous block store with a registered, resettable read port.
module slow_mem_array
    import slow_mem_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [BLK_W-1:0] wdata,
    output logic [BLK_W-1:0] rdata
);
    logic [BLK_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Only the read data register is reset; the block contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/slow_mem_responder.sv
// slow_mem_responder: fixed-latency block read/write responder with completion pulse and op counters.
module slow_mem_responder
    import slow_mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [BLK_W-1:0]  mem_wdata,
    output logic [BLK_W-1:0]  mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t           state;
    op_t              op, op_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [BLK_W-1:0] wdata, wdata_n;
    logic [CNT_W-1:0] cnt;
    logic             req, go_resp, addr_unused;

    assign req = mem_read | mem_write;
    assign busy = state != IDLE;
    assign addr_unused = ^mem_addr[ADDR_W-1:IDX_W];

    // With LATENCY==1 the array is accessed on the accepting edge, so it sees the live request.
    always_comb begin
        op_n    = state == IDLE ? (mem_write ? OP_WR : OP_RD) : op;
        idx_n   = state == IDLE ? mem_addr[IDX_W-1:0] : idx;
        wdata_n = state == IDLE ? mem_wdata : wdata;
        go_resp = rst_n && ((state == IDLE && req && LATENCY == 1) || (state == BUSY && cnt == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_RD;
            idx       <= '0;
            wdata     <= '0;
            cnt       <= '0;
            mem_ready <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            mem_ready <= go_resp;
            case (state)
                IDLE: if (req) begin
                    op    <= op_n;
                    idx   <= idx_n;
                    wdata <= wdata_n;
                    cnt   <= CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
                    state <= LATENCY == 1 ? RESP : BUSY;
                end
                BUSY: begin
                    if (cnt == '0) state <= RESP;
                    else cnt <= cnt - 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    if (op == OP_WR) wr_count <= wr_count + 1'b1;
                    else rd_count <= rd_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    slow_mem_array #(.IDX_W(IDX_W)) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (go_resp && op_n == OP_WR),
        .re   (go_resp && op_n == OP_RD),
        .idx  (idx_n),
        .wdata(wdata_n),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder: timeline model of the responder checked every cycle, plus directed literal checks.
module tb_slow_mem_responder;
    localparam int L = 4;
    localparam int IW = 10;

    logic clk = 0, rst_n = 0;
    logic rd = 0, wr = 0;
    logic [27:0] addr = '0;
    logic [127:0] wd = '0;
    logic [127:0] rdata;
    logic ready, busy;
    logic [31:0] rdc, wrc;

    logic rd1 = 0, wr1 = 0;
    logic [27:0] addr1 = '0;
    logic [127:0] wd1 = '0;
    logic [127:0] rdata1;
    logic ready1, busy1;
    logic [31:0] rdc1, wrc1;

    slow_mem_responder #(.LATENCY(L), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_addr(addr),
        .mem_wdata(wd), .mem_rdata(rdata), .mem_ready(ready), .busy(busy),
        .rd_count(rdc), .wr_count(wrc)
    );

    slow_mem_responder #(.LATENCY(1), .IDX_W(IW)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_rdata(rdata1), .mem_ready(ready1), .busy(busy1),
        .rd_count(rdc1), .wr_count(wrc1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted op completes L edges later, then its counter bumps one edge after that.
    logic [127:0] m_mem [int];
    bit m_active, m_wr, e_ready, e_known;
    int m_rem, m_idx;
    logic [127:0] m_wd, e_rdata;
    logic [31:0] e_rd, e_wr;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 0; e_ready = 0; e_rdata = '0; e_known = 1; e_rd = 0; e_wr = 0;
        end else if (e_ready) begin
            if (m_wr) e_wr++;
            else e_rd++;
            e_ready = 0;
        end else begin
            if (!m_active && (rd || wr)) begin
                m_active = 1; m_wr = wr; m_idx = int'(addr % (28'd1 << IW)); m_wd = wd; m_rem = L;
            end
            if (m_active) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 0;
                    e_ready = 1;
                    if (m_wr) m_mem[m_idx] = m_wd;
                    else begin
                        e_known = m_mem.exists(m_idx);
                        e_rdata = e_known ? m_mem[m_idx] : '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, e_ready);
            chk("busy", busy, m_active || e_ready);
            chk("rd_count", rdc, e_rd);
            chk("wr_count", wrc, e_wr);
            if (e_known) chk("rdata", rdata, e_rdata);
        end
    end

    task automatic op4(bit r, bit w, logic [27:0] a, logic [127:0] d, bit mut,
                       logic [27:0] ma, logic [127:0] md, output int s, output int rc);
        @(negedge clk);
        rd = r; wr = w; addr = a; wd = d; s = cyc; rc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mut && cyc - s == 2) begin addr = ma; wd = md; end
            if (ready) begin rc = cyc; break; end
        end
        rd = 0; wr = 0;
        if (rc < 0) begin
            n_vec++; n_err++;
            $display("FAIL op_timeout: got no mem_ready expected one within 20 cycles");
        end
    endtask

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DB = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    localparam logic [127:0] DX = 128'h5A5A_5A5A_0F0F_0F0F_F0F0_F0F0_A5A5_A5A5;
    localparam logic [127:0] DC = 128'hC0DE_C0DE_1234_5678_9ABC_DEF0_0BAD_F00D;
    localparam logic [127:0] D1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [127:0] D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [127:0] W1 = 128'hFEED_FACE_CAFE_BEEF_0000_0001_0000_0002;

    initial begin
        int s1, r1, s2, r2, c0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        chk("reset_rdata", rdata, 128'h0);
        chk("reset_counts", {rdc, wrc}, 64'h0);

        op4(0, 1, 28'h0000010, D0, 0, '0, '0, s1, r1);
        op4(1, 0, 28'h0000010, '0, 0, '0, '0, s2, r2);
        chk("wr_ready_cycle", 32'(r1 - s1), 32'd4);
        chk("rd_ready_cycle", 32'(r2 - s1), 32'd9);
        chk("rd_data", rdata, D0);
        @(negedge clk);
        chk("counts_after_t2", {rdc, wrc}, {32'd1, 32'd1});

        op4(0, 1, 28'h0000005, DA, 0, '0, '0, s1, r1);
        op4(0, 1, 28'h0000405, DB, 0, '0, '0, s1, r1);
        op4(1, 0, 28'h0000005, '0, 0, '0, '0, s1, r1);
        chk("alias_data", rdata, DB);

        op4(1, 1, 28'h0000007, DX, 0, '0, '0, s1, r1);
        @(negedge clk);
        chk("simul_counts", {rdc, wrc}, {32'd2, 32'd4});
        chk("simul_rdata_held", rdata, DB);
        op4(1, 0, 28'h0000007, '0, 0, '0, '0, s1, r1);
        chk("simul_data", rdata, DX);

        op4(0, 1, 28'h0000009, DC, 1, 28'h000000A, D2, s1, r1);
        op4(1, 0, 28'h0000009, '0, 0, '0, '0, s1, r1);
        chk("busy_change_data", rdata, DC);

        @(negedge clk);
        wr1 = 1; addr1 = 28'h3; wd1 = W1;
        @(negedge clk);
        chk("l1_wr_ready", ready1, 1'b1);
        wr1 = 0;
        @(negedge clk);
        rd1 = 1; addr1 = 28'h3;
        @(negedge clk);
        chk("l1_rd_ready_c1", ready1, 1'b1);
        chk("l1_rd_data", rdata1, W1);
        @(negedge clk);
        chk("l1_idle_c2", {ready1, busy1}, 2'b00);
        @(negedge clk);
        chk("l1_rd_ready_c3", ready1, 1'b1);
        rd1 = 0;
        @(negedge clk);
        chk("l1_counts", {rdc1, wrc1, busy1}, {32'd2, 32'd1, 1'b0});

        op4(0, 1, 28'h0000030, D1, 0, '0, '0, s1, r1);
        @(negedge clk);
        wr = 1; addr = 28'h0000030; wd = D2; c0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 0; wr = 0;
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_count", rdc, 32'd0);
        chk("rst_rdata", rdata, 128'h0);
        @(negedge clk);
        rst_n = 1;
        op4(1, 0, 28'h0000030, '0, 0, '0, '0, s1, r1);
        chk("rst_old_data", rdata, D1);
        chk("rst_rd_latency", 32'(r1 - s1), 32'd4);
        @(negedge clk);
        chk("rst_counts_after", {rdc, wrc}, {32'd1, 32'd0});

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
